// File: rtl/sprite_pkg.sv
// +-----------------------------------------------------------------------------+
// | sprite_pkg : shared types, palette and helpers for the sprite compositor     |
// | Revision   : 1.0  initial release                                           |
// +-----------------------------------------------------------------------------+
`default_nettype none

package sprite_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Entry 0 is never displayed: palette index 0 means transparent.
    localparam rgb_t PALETTE [16] = '{
        24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'h808080,
        24'h800000, 24'h008000, 24'h000080, 24'h808000,
        24'h800080, 24'h008080, 24'hC0C0C0, 24'hFF8000
    };

    localparam rgb_t TEXT_COLOR = 24'hFFFFFF;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_hit.sv
// +-----------------------------------------------------------------------------+
// | sprite_hit : single-channel bounding-box test returning hit, row and column  |
// | Revision   : 1.0  initial release                                           |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sprite_hit
    import sprite_pkg::*;
#(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int COL_W = clog2(SPR_W),
    parameter int ROW_W = clog2(SPR_H)
) (
    input  logic             en_i,
    input  logic [9:0]       draw_x_i,
    input  logic [9:0]       draw_y_i,
    input  logic [9:0]       spr_x_i,
    input  logic [9:0]       spr_y_i,
    output logic             hit_o,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o
);

    logic [10:0] x_end_w;
    logic [10:0] y_end_w;

    // 11-bit ends so a sprite near the right/bottom edge never wraps to 0.
    assign x_end_w = {1'b0, spr_x_i} + 11'(SPR_W);
    assign y_end_w = {1'b0, spr_y_i} + 11'(SPR_H);

    assign hit_o = en_i
                 & (draw_x_i >= spr_x_i) & ({1'b0, draw_x_i} < x_end_w)
                 & (draw_y_i >= spr_y_i) & ({1'b0, draw_y_i} < y_end_w);

    assign col_o = COL_W'(draw_x_i - spr_x_i);
    assign row_o = ROW_W'(draw_y_i - spr_y_i);

endmodule

`default_nettype wire

// File: rtl/sprite_compositor.sv
// +-----------------------------------------------------------------------------+
// | sprite_compositor : 3-stage multi-sprite compositor over background + text   |
// | Optional macro SPRITE_COLLISION_EN adds per-frame bounding-box collisions.   |
// | Revision          : 1.0  initial release                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int TILE_W      = 3,
    parameter int ROM_AW      = 8
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          frame_start,
    input  logic                          pixel_valid,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [10*NUM_SPRITES-1:0]     spr_x,
    input  logic [10*NUM_SPRITES-1:0]     spr_y,
    input  logic [NUM_SPRITES-1:0]        spr_en,
    input  logic [TILE_W*NUM_SPRITES-1:0] spr_tile,
    input  logic [7:0]                    bg_r,
    input  logic [7:0]                    bg_g,
    input  logic [7:0]                    bg_b,
    input  logic                          text_on,
    output logic [ROM_AW-1:0]             rom_addr,
    input  logic [4*SPR_W-1:0]            rom_data,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          out_valid
`ifdef SPRITE_COLLISION_EN
    ,
    output logic [NUM_SPRITES-1:0]        collision
`endif
);

    localparam int COL_W = clog2(SPR_W);
    localparam int ROW_W = clog2(SPR_H);

    // Per-frame shadow copies of the sprite attributes.
    logic [10*NUM_SPRITES-1:0]     spr_x_q;
    logic [10*NUM_SPRITES-1:0]     spr_y_q;
    logic [NUM_SPRITES-1:0]        spr_en_q;
    logic [TILE_W*NUM_SPRITES-1:0] spr_tile_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            spr_x_q    <= '0;
            spr_y_q    <= '0;
            spr_en_q   <= '0;
            spr_tile_q <= '0;
        end else if (frame_start) begin
            spr_x_q    <= spr_x;
            spr_y_q    <= spr_y;
            spr_en_q   <= spr_en;
            spr_tile_q <= spr_tile;
        end
    end

    logic [NUM_SPRITES-1:0] hit_w;
    logic [ROW_W-1:0]       row_w [NUM_SPRITES];
    logic [COL_W-1:0]       col_w [NUM_SPRITES];

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        sprite_hit #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H),
            .COL_W (COL_W),
            .ROW_W (ROW_W)
        ) u_hit (
            .en_i     (spr_en_q[i]),
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .spr_x_i  (spr_x_q[10*i +: 10]),
            .spr_y_i  (spr_y_q[10*i +: 10]),
            .hit_o    (hit_w[i]),
            .row_o    (row_w[i]),
            .col_o    (col_w[i])
        );
    end

    logic [ROM_AW-1:0] rom_addr_d;
    logic [COL_W-1:0]  col_d;

    // Walk from lowest priority upward so channel 0 is the final winner.
    always_comb begin
        rom_addr_d = '0;
        col_d      = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_w[i]) begin
                rom_addr_d = ROM_AW'(spr_tile_q[TILE_W*i +: TILE_W]) * ROM_AW'(SPR_H)
                           + ROM_AW'(row_w[i]);
                col_d      = col_w[i];
            end
        end
    end

    logic [ROM_AW-1:0] rom_addr_q;
    logic [COL_W-1:0]  col1_q, col2_q;
    logic              hit1_q, hit2_q;
    rgb_t              bg1_q, bg2_q;
    logic              text1_q, text2_q;
    logic              valid1_q, valid2_q;
    rgb_t              pix_d, pix_q;
    logic              out_valid_q;
    logic [3:0]        idx_w;

    assign idx_w = rom_data[4*col2_q +: 4];

    // Transparent winner pixels fall through to background, never to lower sprites.
    always_comb begin
        pix_d = '0;
        if (valid2_q) begin
            if (text2_q) begin
                pix_d = TEXT_COLOR;
            end else if (hit2_q && (idx_w != 4'd0)) begin
                pix_d = PALETTE[idx_w];
            end else begin
                pix_d = bg2_q;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            col1_q      <= '0;
            hit1_q      <= 1'b0;
            bg1_q       <= '0;
            text1_q     <= 1'b0;
            valid1_q    <= 1'b0;
            col2_q      <= '0;
            hit2_q      <= 1'b0;
            bg2_q       <= '0;
            text2_q     <= 1'b0;
            valid2_q    <= 1'b0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            col1_q      <= col_d;
            hit1_q      <= |hit_w;
            bg1_q       <= {bg_r, bg_g, bg_b};
            text1_q     <= text_on;
            valid1_q    <= pixel_valid;
            col2_q      <= col1_q;
            hit2_q      <= hit1_q;
            bg2_q       <= bg1_q;
            text2_q     <= text1_q;
            valid2_q    <= valid1_q;
            pix_q       <= pix_d;
            out_valid_q <= valid2_q;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign VGA_R     = pix_q.r;
    assign VGA_G     = pix_q.g;
    assign VGA_B     = pix_q.b;
    assign out_valid = out_valid_q;

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] coll_add_w;
    logic [NUM_SPRITES-1:0] coll_acc_q;
    logic [NUM_SPRITES-1:0] collision_q;

    // Two or more bits set <=> clearing the lowest set bit leaves something.
    assign coll_add_w = (pixel_valid && ((hit_w & (hit_w - NUM_SPRITES'(1))) != '0))
                      ? hit_w : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            coll_acc_q  <= '0;
            collision_q <= '0;
        end else if (frame_start) begin
            collision_q <= coll_acc_q;
            coll_acc_q  <= coll_add_w;
        end else begin
            coll_acc_q  <= coll_acc_q | coll_add_w;
        end
    end

    assign collision = collision_q;
`endif

endmodule

`default_nettype wire

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Pipelined successor to the single-sprite color mapper: composites NUM_SPRITES positioned, tiled, palette-indexed sprites over the background colour and the text overlay for each VGA pixel.
- Sprite positions, enables and tile indices are latched once per frame so that game logic cannot tear a frame.
- Uses a single synchronous sprite ROM port.
- Sits between the background/text generators and the VGA DAC outputs.

Parameters:
- NUM_SPRITES, 4, number of sprite channels; channel 0 has the highest priority.
- SPR_W, 32, sprite width in pixels.
- SPR_H, 32, sprite height in pixels; ROM rows per tile.
- TILE_W, 3, tile-index width per channel.
- ROM_AW, 8, ROM address width; must be at least TILE_W+clog2(SPR_H).

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of frame (vsync edge).
- pixel_valid  in  1  DrawX/DrawY and colour inputs are valid this cycle.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- spr_x  in  10*NUM_SPRITES  sprite top-left X, channel i at [10i+:10].
- spr_y  in  10*NUM_SPRITES  sprite top-left Y.
- spr_en  in  NUM_SPRITES  per-channel enable.
- spr_tile  in  TILE_W*NUM_SPRITES  tile index per channel.
- bg_r, bg_g, bg_b  in  8 each  background colour for the pixel.
- text_on  in  1  text pixel lit (font bit already resolved).
- rom_addr  out  ROM_AW  sprite ROM row address.
- rom_data  in  4*SPR_W  ROM row, 1-cycle read latency; pixel c at [4c+:4].
- VGA_R, VGA_G, VGA_B  out  8 each  composited colour.
- out_valid  out  1  VGA_* correspond to a valid pixel.

Behaviour:
- Reset: all shadow registers, pipeline registers, rom_addr, VGA_*, out_valid and collision are 0.
- Shadow latch: on a cycle with frame_start=1, copy spr_x/spr_y/spr_en/spr_tile into shadows at that edge. A pixel presented in the same cycle uses the previous shadows.
- S0 (input cycle t), hit test per channel:
  - hit_i = en_i & DrawX>=x_i & DrawX<x_i+SPR_W & DrawY>=y_i & DrawY<y_i+SPR_H.
  - Sums are computed at 11 bits; there is no wrap, so sprites extend off-screen cleanly.
  - sel = lowest-index hit; any_hit = OR of hits.
  - Registered at t+1: rom_addr = tile_sel*SPR_H + (DrawY-y_sel); col = DrawX-x_sel (clog2(SPR_W) bits); any_hit, bg, text_on, valid.
  - No hit: rom_addr=0, any_hit=0.
- S1 (t+1): ROM presents rom_data at t+2. Delay col, any_hit, bg, text_on and valid one stage.
- S2 (t+2): idx = rom_data[4*col+:4]. Output registered at t+3:
  - text_on -> FFFFFF.
  - else any_hit & idx!=0 -> palette[idx].
  - else bg.
  - idx 0 is transparent. Lower-priority sprites are NOT shown through a transparent pixel of the winning sprite.
- Latency: exactly 3 cycles from pixel_valid to out_valid. Throughput is one pixel per cycle with no stalls.
- When out_valid=0, VGA_* are driven to 0 (blanking).
- Reset mid-frame: pipeline flushes to 0 immediately. Shadows stay 0 (all sprites off) until the next frame_start.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Enabled: adds output port collision [NUM_SPRITES] and an internal accumulator.
  - For a valid pixel with >=2 hits, OR the hit vector into the accumulator.
  - On frame_start: collision <= accumulator, and the accumulator is reloaded with the current cycle's contribution (or 0). The same-cycle pixel therefore counts toward the new frame.
  - Collision uses bounding boxes, not opaque pixels.
  - collision resets to 0.
- Disabled: no port and no logic.

Decomposition:
- Package sprite_pkg holds:
  - typedef rgb_t (struct r,g,b 8-bit);
  - localparam PALETTE[16] of rgb_t (entry 0 unused/transparent);
  - TEXT_COLOR = FFFFFF;
  - function clog2 helper.
- One sub-module, sprite_hit: a single-channel bounding-box compare that returns hit, row and col. It is instantiated NUM_SPRITES times via generate. The priority encoder stays in the top.

Test Plan:
- Reset, no frame_start, sweep pixels -> outputs equal bg delayed 3 cycles; rom_addr stays 0.
- Channel 0 at (100,50), tile 2, en; ROM row of all 0x3; pixel (100,50) -> rom_addr=64 at t+1; VGA=PALETTE[3] at t+3. Pixel (132,50) -> bg.
- Channels 0 and 1 both cover (200,200), channel-0 pixel idx=0 -> output is bg, not channel 1. Swap so channel-0 idx=5 -> PALETTE[5].
- text_on=1 over an opaque sprite pixel -> FFFFFF.
- Change spr_x from 10 to 300 mid-frame without frame_start -> rendering still at X=10. Pulse frame_start -> next pixels render at X=300.
- SPRITE_COLLISION_EN: sprites 1 and 3 overlap at one pixel during the frame -> after next frame_start, collision=4'b1010. A frame with no overlap -> 0.
